// File: rtl/axi_slave_mem_if.sv
// ----------------------------------------------------------------------------
// axi_slave_mem_if
// Purpose : AXI4 bundle (AW/W/B/AR/R channels, 32-bit data) between an AXI4
//           master and the axi_slave_mem model memory.
// Modports: slave  - used by axi_slave_mem (drives READY/B/R outputs)
//           master - used by the bus master (drives addresses, data, VALIDs)
// Params  : ADDR_WIDTH - AXI address width
// ----------------------------------------------------------------------------
interface axi_slave_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  // Write address channel
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;
  // Write data channel
  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  // Write response channel
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  // Read address channel
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  // Read data channel
  logic [31:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_slave_mem.sv
// ----------------------------------------------------------------------------
// axi_slave_mem
// Purpose : Synthesizable AXI4 slave memory answering INCR bursts of 32-bit
//           words. Independent write FSM (IDLE/DATA/RESP) and read FSM
//           (IDLE/DATA), each handling one outstanding transaction.
// Ports   : ACLK    - clock, all logic on rising edge
//           ARESET  - synchronous active-high reset (FSMs only, not memory)
//           S00_AXI - AXI4 slave modport (AW/W/B/AR/R channels)
// Params  : ADDR_WIDTH - address width
//           MEM_WORDS  - depth in 32-bit words (power of two, >= 2)
//           BASE_ADDR  - byte address of word 0
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module axi_slave_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic             ACLK,
  input  logic             ARESET,
  axi_slave_mem_if.slave   S00_AXI
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Only 4-byte beats in INCR mode are supported.
  function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst);
    return (size == 3'b010) && (burst == 2'b01);
  endfunction

  // In range when at or above the base and the word offset fits the array.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (IDX_W + 2)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> 2;
    return IDX_W'(off);
  endfunction

  logic [31:0] r_mem [MEM_WORDS];

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  logic [1:0]            r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wcnt;
  logic                  r_werr;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_wlast_beat;
  logic w_wbeat_ok;

  assign w_aw_hs      = S00_AXI.AWVALID && r_awready;
  assign w_w_hs       = S00_AXI.WVALID && r_wready;
  assign w_b_hs       = r_bvalid && S00_AXI.BREADY;
  assign w_wlast_beat = (r_wcnt == 8'd0);
  // A beat commits only if the burst is still clean, the address maps to the
  // array and WLAST agrees with the beat count; any failure poisons the rest.
  assign w_wbeat_ok   = !r_werr && addr_in_range(r_waddr) &&
                        (S00_AXI.WLAST == w_wlast_beat);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs && w_wlast_beat) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wbeat_ok ? RESP_OKAY : RESP_SLVERR;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_aw_hs) begin
      r_waddr <= S00_AXI.AWADDR;
      r_wcnt  <= S00_AXI.AWLEN;
      r_werr  <= !burst_legal(S00_AXI.AWSIZE, S00_AXI.AWBURST);
    end else if (w_w_hs) begin
      r_waddr <= r_waddr + ADDR_WIDTH'(4);
      r_wcnt  <= r_wcnt - 8'd1;
      r_werr  <= !w_wbeat_ok;
    end
  end

  // Memory is never reset; the ARESET gate stops a handshake that coincides
  // with reset from landing.
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_w_hs && w_wbeat_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (S00_AXI.WSTRB[i]) begin
          r_mem[word_idx(r_waddr)][8*i +: 8] <= S00_AXI.WDATA[8*i +: 8];
        end
      end
    end
  end

  assign S00_AXI.AWREADY = r_awready;
  assign S00_AXI.WREADY  = r_wready;
  assign S00_AXI.BVALID  = r_bvalid;
  assign S00_AXI.BRESP   = r_bresp;

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [0:0]            r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic [ADDR_WIDTH-1:0] r_raddr;   // address of the next beat to load
  logic [7:0]            r_rcnt;    // beats remaining after the one on the bus
  logic                  r_rerr;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_ld;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic [7:0]            w_ld_cnt;
  logic                  w_ld_err;
  logic                  w_ld_ok;

  assign w_ar_hs = S00_AXI.ARVALID && r_arready;
  assign w_r_hs  = r_rvalid && S00_AXI.RREADY;

  // Beat loader source: the AR request itself for beat 0, the stored burst
  // state for every later beat.
  always_comb begin
    if (r_rstate == R_IDLE) begin
      w_ld_addr = S00_AXI.ARADDR;
      w_ld_cnt  = S00_AXI.ARLEN;
      w_ld_err  = !burst_legal(S00_AXI.ARSIZE, S00_AXI.ARBURST);
      w_ld      = w_ar_hs;
    end else begin
      w_ld_addr = r_raddr;
      w_ld_cnt  = r_rcnt - 8'd1;
      w_ld_err  = r_rerr;
      w_ld      = w_r_hs && !r_rlast;
    end
  end

  assign w_ld_ok = !w_ld_err && addr_in_range(w_ld_addr);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs && r_rlast) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
      // Memory read uses pre-edge contents, so a same-edge write to the same
      // word is not visible in this beat.
      if (w_ld) begin
        r_rdata <= w_ld_ok ? r_mem[word_idx(w_ld_addr)] : 32'h0;
        r_rresp <= w_ld_ok ? RESP_OKAY : RESP_SLVERR;
        r_rlast <= (w_ld_cnt == 8'd0);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_ld) begin
      r_raddr <= w_ld_addr + ADDR_WIDTH'(4);
      r_rcnt  <= w_ld_cnt;
      r_rerr  <= w_ld_err;
    end
  end

  assign S00_AXI.ARREADY = r_arready;
  assign S00_AXI.RVALID  = r_rvalid;
  assign S00_AXI.RDATA   = r_rdata;
  assign S00_AXI.RRESP   = r_rresp;
  assign S00_AXI.RLAST   = r_rlast;

endmodule

// File: tb/tb_axi_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_axi_slave_mem
// Table of write/read bursts driven through axi_slave_mem; B and R responses
// are predicted into queues and checked by negedge monitors. Hand-written
// sequences cover reset values, handshake latencies and reset mid-burst.
// ----------------------------------------------------------------------------
module tb_axi_slave_mem;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic ACLK;
  logic ARESET;

  axi_slave_mem_if #(.ADDR_WIDTH(32)) ifc ();

  axi_slave_mem #(
    .ADDR_WIDTH (32),
    .MEM_WORDS  (1024),
    .BASE_ADDR  (32'h0000_0000)
  ) u_dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .S00_AXI (ifc.slave)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] data0;     // beat i carries data0 + i
    int          bad_last;  // beat index carrying WLAST, -1 for correct WLAST
    bit          toggle;    // toggle RREADY each cycle on reads
    logic [1:0]  exp_bresp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  vec_t        vq[$];
  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  logic [31:0] mdl [1024];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: handshake never happened, expected within budget", nm);
  endtask

  // R monitor: every visible beat (stalled or not) must match the head.
  always @(negedge ACLK) begin
    if (!ARESET && ifc.RVALID) begin
      if (rq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL r_unexpected: got RVALID=1, expected 0");
      end else begin
        chk("rdata", ifc.RDATA, rq[0].data);
        chk("rresp", {30'b0, ifc.RRESP}, {30'b0, rq[0].resp});
        chk("rlast", {31'b0, ifc.RLAST}, {31'b0, rq[0].last});
        if (ifc.RREADY) void'(rq.pop_front());
      end
    end
  end

  always @(negedge ACLK) begin
    if (!ARESET && ifc.BVALID) begin
      if (bq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL b_unexpected: got BVALID=1, expected 0");
      end else begin
        chk("bresp", {30'b0, ifc.BRESP}, {30'b0, bq[0]});
        if (ifc.BREADY) void'(bq.pop_front());
      end
    end
  end

  // which: 0 AWREADY, 1 WREADY, 2 ARREADY. Returns just after the handshake edge.
  task automatic wait_ready(input int which, input string nm);
    int  n;
    logic rdy;
    n = 0;
    forever begin
      @(negedge ACLK);
      rdy = (which == 0) ? ifc.AWREADY : (which == 1) ? ifc.WREADY : ifc.ARREADY;
      if (rdy) break;
      n++;
      if (n > 100) begin
        timeout_fail(nm);
        break;
      end
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic model_write(input vec_t v);
    logic        err;
    logic [31:0] a;
    logic        wl;
    err = !(v.size == 3'd2 && v.burst == 2'd1);
    for (int i = 0; i <= int'(v.len); i++) begin
      a  = v.addr + 32'(4 * i);
      wl = (v.bad_last >= 0) ? (i == v.bad_last) : (i == int'(v.len));
      if (!err && a < 32'h1000 && (wl == (i == int'(v.len)))) begin
        for (int b = 0; b < 4; b++)
          if (v.strb[b]) mdl[a[11:2]][8*b +: 8] = (v.data0 + 32'(i)) >> (8 * b);
      end else begin
        err = 1'b1;
      end
    end
  endtask

  task automatic push_read(input vec_t v);
    rbeat_t      rb;
    logic [31:0] a;
    logic        ok;
    for (int i = 0; i <= int'(v.len); i++) begin
      a       = v.addr + 32'(4 * i);
      ok      = (v.size == 3'd2) && (v.burst == 2'd1) && (a < 32'h1000);
      rb.data = ok ? mdl[a[11:2]] : 32'h0;
      rb.resp = ok ? OKAY : SLVERR;
      rb.last = (i == int'(v.len));
      rq.push_back(rb);
    end
  endtask

  task automatic do_write(input vec_t v);
    int n;
    bq.push_back(v.exp_bresp);
    ifc.AWADDR  = v.addr;
    ifc.AWLEN   = v.len;
    ifc.AWSIZE  = v.size;
    ifc.AWBURST = v.burst;
    ifc.AWVALID = 1'b1;
    wait_ready(0, "aw_timeout");
    ifc.AWVALID = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      ifc.WDATA  = v.data0 + 32'(i);
      ifc.WSTRB  = v.strb;
      ifc.WLAST  = (v.bad_last >= 0) ? (i == v.bad_last) : (i == int'(v.len));
      ifc.WVALID = 1'b1;
      wait_ready(1, "w_timeout");
    end
    ifc.WVALID = 1'b0;
    ifc.WLAST  = 1'b0;
    model_write(v);
    n = 0;
    while (bq.size() > 0 && n < 50) begin
      @(posedge ACLK);
      n++;
    end
    if (bq.size() > 0) begin
      timeout_fail("b_timeout");
      bq.delete();
    end
    #1;
  endtask

  task automatic do_read(input vec_t v);
    int n;
    push_read(v);
    ifc.ARADDR  = v.addr;
    ifc.ARLEN   = v.len;
    ifc.ARSIZE  = v.size;
    ifc.ARBURST = v.burst;
    ifc.ARVALID = 1'b1;
    wait_ready(2, "ar_timeout");
    ifc.ARVALID = 1'b0;
    ifc.RREADY  = 1'b1;
    n = 0;
    forever begin
      @(posedge ACLK);
      #1;
      if (rq.size() == 0) break;
      if (v.toggle) ifc.RREADY = ~ifc.RREADY;
      n++;
      if (n > 600) begin
        timeout_fail("r_timeout");
        rq.delete();
        break;
      end
    end
    ifc.RREADY = 1'b0;
  endtask

  function automatic vec_t wv(input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [3:0] strb,
                              input logic [31:0] d0, input int bad_last,
                              input logic [1:0] exp_b);
    vec_t v;
    v = '{wr: 1'b1, addr: addr, len: len, size: 3'd2, burst: burst, strb: strb,
          data0: d0, bad_last: bad_last, toggle: 1'b0, exp_bresp: exp_b};
    return v;
  endfunction

  function automatic vec_t rv(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input bit toggle);
    vec_t v;
    v = '{wr: 1'b0, addr: addr, len: len, size: size, burst: 2'd1, strb: 4'h0,
          data0: 32'h0, bad_last: -1, toggle: toggle, exp_bresp: OKAY};
    return v;
  endfunction

  initial begin
    vec_t v;

    ifc.AWADDR = '0; ifc.AWLEN = '0; ifc.AWSIZE = 3'd2; ifc.AWBURST = 2'd1;
    ifc.AWVALID = 1'b0; ifc.WDATA = '0; ifc.WSTRB = '0; ifc.WLAST = 1'b0;
    ifc.WVALID = 1'b0; ifc.BREADY = 1'b1;
    ifc.ARADDR = '0; ifc.ARLEN = '0; ifc.ARSIZE = 3'd2; ifc.ARBURST = 2'd1;
    ifc.ARVALID = 1'b0; ifc.RREADY = 1'b0;
    ARESET = 1'b1;

    // Vector table
    vq.push_back(wv(32'h10,  8'd0,  2'd1, 4'hF,    32'hDEADBEEF, -1, OKAY));
    vq.push_back(rv(32'h10,  8'd0,  3'd2, 1'b0));
    vq.push_back(wv(32'h0,   8'd15, 2'd1, 4'hF,    32'h0,        -1, OKAY));
    vq.push_back(rv(32'h0,   8'd15, 3'd2, 1'b1));
    vq.push_back(wv(32'h20,  8'd0,  2'd1, 4'hF,    32'hFFFFFFFF, -1, OKAY));
    vq.push_back(wv(32'h20,  8'd0,  2'd1, 4'b0101, 32'h12345678, -1, OKAY));
    vq.push_back(rv(32'h20,  8'd0,  3'd2, 1'b0));
    vq.push_back(wv(32'hFF8, 8'd0,  2'd1, 4'hF,    32'hA5A5A5A5, -1, OKAY));
    vq.push_back(wv(32'hFFC, 8'd1,  2'd1, 4'hF,    32'h11110000, -1, SLVERR));
    vq.push_back(rv(32'hFF8, 8'd2,  3'd2, 1'b0));
    vq.push_back(rv(32'h1000, 8'd0, 3'd2, 1'b0));
    vq.push_back(wv(32'h40,  8'd0,  2'd1, 4'hF,    32'h0BADF00D, -1, OKAY));
    vq.push_back(wv(32'h40,  8'd0,  2'd0, 4'hF,    32'hCAFEBABE, -1, SLVERR));
    vq.push_back(rv(32'h40,  8'd0,  3'd2, 1'b0));
    vq.push_back(wv(32'h60,  8'd3,  2'd1, 4'hF,    32'h00007000, -1, OKAY));
    vq.push_back(wv(32'h60,  8'd3,  2'd1, 4'hF,    32'h00005000,  0, SLVERR));
    vq.push_back(rv(32'h60,  8'd3,  3'd2, 1'b1));
    vq.push_back(rv(32'h10,  8'd0,  3'd3, 1'b0));

    // Reset values while ARESET is held
    repeat (10) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", {31'b0, ifc.AWREADY}, 32'h0);
    chk("rst_wready",  {31'b0, ifc.WREADY},  32'h0);
    chk("rst_bvalid",  {31'b0, ifc.BVALID},  32'h0);
    chk("rst_bresp",   {30'b0, ifc.BRESP},   32'h0);
    chk("rst_arready", {31'b0, ifc.ARREADY}, 32'h0);
    chk("rst_rvalid",  {31'b0, ifc.RVALID},  32'h0);
    chk("rst_rdata",   ifc.RDATA,            32'h0);
    chk("rst_rresp",   {30'b0, ifc.RRESP},   32'h0);
    chk("rst_rlast",   {31'b0, ifc.RLAST},   32'h0);
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("rel_awready_low", {31'b0, ifc.AWREADY}, 32'h0);
    @(negedge ACLK);
    chk("rel_awready", {31'b0, ifc.AWREADY}, 32'h1);
    chk("rel_arready", {31'b0, ifc.ARREADY}, 32'h1);
    @(posedge ACLK);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].wr) do_write(vq[i]);
      else          do_read(vq[i]);
    end

    // Single-beat write latency with AW and W presented together
    v = wv(32'h80, 8'd0, 2'd1, 4'hF, 32'h600DCAFE, -1, OKAY);
    bq.push_back(OKAY);
    ifc.AWADDR = v.addr; ifc.AWLEN = 8'd0; ifc.AWSIZE = 3'd2; ifc.AWBURST = 2'd1;
    ifc.AWVALID = 1'b1;
    ifc.WDATA = v.data0; ifc.WSTRB = 4'hF; ifc.WLAST = 1'b1; ifc.WVALID = 1'b1;
    @(negedge ACLK);
    chk("lat_awready", {31'b0, ifc.AWREADY}, 32'h1);
    chk("lat_wready0", {31'b0, ifc.WREADY},  32'h0);
    @(posedge ACLK);
    #1 ifc.AWVALID = 1'b0;
    @(negedge ACLK);
    chk("lat_wready1", {31'b0, ifc.WREADY},  32'h1);
    chk("lat_awready0", {31'b0, ifc.AWREADY}, 32'h0);
    @(posedge ACLK);
    #1 ifc.WVALID = 1'b0; ifc.WLAST = 1'b0;
    @(negedge ACLK);
    chk("lat_bvalid", {31'b0, ifc.BVALID}, 32'h1);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("lat_bvalid0",  {31'b0, ifc.BVALID},  32'h0);
    chk("lat_awready1", {31'b0, ifc.AWREADY}, 32'h1);
    model_write(v);
    chk("lat_bq_empty", 32'(bq.size()), 32'h0);
    @(posedge ACLK);
    #1;
    do_read(rv(32'h80, 8'd0, 3'd2, 1'b0));

    // Reset in the middle of an 8-beat read
    push_read(rv(32'h0, 8'd7, 3'd2, 1'b0));
    ifc.ARADDR = 32'h0; ifc.ARLEN = 8'd7; ifc.ARSIZE = 3'd2; ifc.ARBURST = 2'd1;
    ifc.ARVALID = 1'b1;
    wait_ready(2, "ar_timeout_rst");
    ifc.ARVALID = 1'b0;
    ifc.RREADY  = 1'b1;
    @(negedge ACLK);
    chk("mid_rvalid_rise", {31'b0, ifc.RVALID}, 32'h1);
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b1;
    rq.delete();
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mid_rvalid_rst",  {31'b0, ifc.RVALID},  32'h0);
    chk("mid_arready_rst", {31'b0, ifc.ARREADY}, 32'h0);
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    ifc.RREADY = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mid_arready_rel", {31'b0, ifc.ARREADY}, 32'h1);
    @(posedge ACLK);
    #1;
    do_read(rv(32'h0,  8'd7, 3'd2, 1'b0));
    do_read(rv(32'h20, 8'd0, 3'd2, 1'b0));

    // Partial-strobe result against a literal, independent of the model
    chk("strobe_literal", mdl[8], 32'hFF34FF78);

    repeat (3) @(posedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
